// File: rtl/sys_defs.sv
`default_nettype none
// ============================================================================
// Module      : sys_defs (package)
// Description : Shared system definitions: instruction buffer depth and the
//               decoded-instruction packet passed from decode to dispatch.
// Revision    : 1.0
// ============================================================================
package sys_defs;

    localparam int IB_SZ = 8;

    typedef struct packed {
        logic [31:0] PC;
        logic [31:0] inst;
        logic [4:0]  dest_reg_idx;
        logic [4:0]  rs1_idx;
        logic [4:0]  rs2_idx;
        logic        valid;
    } DP_PACKET;

endpackage
`default_nettype wire

// File: rtl/inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : inst_buffer
// Description : Circular FIFO between decode and dispatch. It pops one packet
//               per cycle when both the ROB and the RS have room.
// Revision    : 1.0
// ============================================================================
module inst_buffer
    import sys_defs::DP_PACKET;
#(
    parameter int IB_SZ = sys_defs::IB_SZ
) (
    input  logic                     clock,
    input  logic                     reset,
    input  DP_PACKET                 if_packet,
    input  logic                     if_valid,
    output logic                     ib_if_ready,
    input  logic                     squash,
    input  logic [1:0]               rob_dp_available,
    input  logic                     rs_available,
    output DP_PACKET                 ib_dp_packet,
    output logic                     ib_dp_valid,
    output logic [1:0]               dp_rob_available,
    output logic [$clog2(IB_SZ):0]   ib_count
);

    localparam int PTR_W = $clog2(IB_SZ);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(IB_SZ);

    DP_PACKET         mem_q [IB_SZ];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Handshakes; squash blocks both so nothing moves in a flushing cycle.
    always_comb begin
        ib_if_ready      = (count_q < C_DEPTH) && !squash;
        push             = if_valid && ib_if_ready;
        ib_dp_valid      = (count_q != '0);
        ib_dp_packet     = ib_dp_valid ? mem_q[head_q] : '0;
        pop              = ib_dp_valid && (rob_dp_available != 2'b00)
                           && rs_available && !squash;
        dp_rob_available = {1'b0, pop};
        ib_count         = count_q;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Push and pop never target the same slot: equal pointers imply empty
    // (no pop) or full (no push).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IB_SZ; i++) mem_q[i] <= '0;
        end else if (squash) begin
            for (int i = 0; i < IB_SZ; i++) mem_q[i] <= '0;
        end else begin
            if (push) mem_q[tail_q] <= if_packet;
            if (pop)  mem_q[head_q] <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_buffer
// Description : Directed self-checking bench for inst_buffer.
// Revision    : 1.0
// ============================================================================
module tb_inst_buffer;
    import sys_defs::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    DP_PACKET   if_packet = '0;
    logic       if_valid = 1'b0;
    logic       squash = 1'b0;
    logic [1:0] rob_dp_available = 2'b00;
    logic       rs_available = 1'b1;
    logic       ib_if_ready;
    DP_PACKET   ib_dp_packet;
    logic       ib_dp_valid;
    logic [1:0] dp_rob_available;
    logic [3:0] ib_count;

    int n_tests = 0;
    int n_fail  = 0;

    inst_buffer #(.IB_SZ(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .if_packet        (if_packet),
        .if_valid         (if_valid),
        .ib_if_ready      (ib_if_ready),
        .squash           (squash),
        .rob_dp_available (rob_dp_available),
        .rs_available     (rs_available),
        .ib_dp_packet     (ib_dp_packet),
        .ib_dp_valid      (ib_dp_valid),
        .dp_rob_available (dp_rob_available),
        .ib_count         (ib_count)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic DP_PACKET mk(input logic [31:0] pc);
        DP_PACKET p;
        p       = '0;
        p.PC    = pc;
        p.inst  = pc ^ 32'h0000_0013;
        p.valid = 1'b1;
        return p;
    endfunction

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            if_packet = mk(base + 32'(4 * i));
            if_valid  = 1'b1;
            tick();
        end
        if_valid = 1'b0;
    endtask

    initial begin
        // Values while reset is held
        #2;
        check_eq("rst_ready", {31'b0, ib_if_ready}, 1);
        check_eq("rst_valid", {31'b0, ib_dp_valid}, 0);
        check_eq("rst_pkt",   {31'b0, |ib_dp_packet}, 0);
        check_eq("rst_dprob", {30'b0, dp_rob_available}, 0);
        check_eq("rst_count", {28'b0, ib_count}, 0);
        tick();
        reset = 1'b0;

        // Push three with the ROB full: nothing dispatches
        rob_dp_available = 2'b00;
        push_n(3, 32'h0);
        #1;
        check_eq("p3_count", {28'b0, ib_count}, 3);
        check_eq("p3_pc",    ib_dp_packet.PC, 32'h0);
        check_eq("p3_dprob", {30'b0, dp_rob_available}, 0);
        check_eq("p3_valid", {31'b0, ib_dp_valid}, 1);

        // Release the ROB: one pop per cycle in order
        rob_dp_available = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq("pop_pc",    ib_dp_packet.PC, 32'(4 * i));
            check_eq("pop_dprob", {30'b0, dp_rob_available}, 1);
            tick();
        end
        #1;
        check_eq("drain_valid", {31'b0, ib_dp_valid}, 0);
        check_eq("drain_count", {28'b0, ib_count}, 0);
        check_eq("drain_dprob", {30'b0, dp_rob_available}, 0);

        // Pushed packet is not dispatchable in its push cycle
        if_packet = mk(32'h100);
        if_valid  = 1'b1;
        #1;
        check_eq("lat_valid0", {31'b0, ib_dp_valid}, 0);
        check_eq("lat_dprob0", {30'b0, dp_rob_available}, 0);
        tick();
        if_valid = 1'b0;
        #1;
        check_eq("lat_valid1", {31'b0, ib_dp_valid}, 1);
        check_eq("lat_pc",     ib_dp_packet.PC, 32'h100);
        check_eq("lat_dprob1", {30'b0, dp_rob_available}, 1);
        tick();

        // Fill to 8; a push attempted alongside a pop is refused while full
        rob_dp_available = 2'b00;
        push_n(8, 32'h200);
        #1;
        check_eq("full_count", {28'b0, ib_count}, 8);
        check_eq("full_ready", {31'b0, ib_if_ready}, 0);
        rob_dp_available = 2'b10;
        if_packet = mk(32'hBAD);
        if_valid  = 1'b1;
        #1;
        check_eq("full_pp_ready", {31'b0, ib_if_ready}, 0);
        check_eq("full_pp_dprob", {30'b0, dp_rob_available}, 1);
        tick();
        if_valid = 1'b0;
        #1;
        check_eq("full_pp_count", {28'b0, ib_count}, 7);
        for (int i = 1; i < 8; i++) begin
            #1;
            check_eq("full_drain_pc", ib_dp_packet.PC, 32'h200 + 32'(4 * i));
            tick();
        end
        #1;
        check_eq("full_drain_valid", {31'b0, ib_dp_valid}, 0);

        // Squash while full with both handshakes requested
        rob_dp_available = 2'b00;
        push_n(8, 32'h400);
        squash    = 1'b1;
        if_packet = mk(32'h777);
        if_valid  = 1'b1;
        rob_dp_available = 2'b10;
        #1;
        check_eq("sqf_ready", {31'b0, ib_if_ready}, 0);
        check_eq("sqf_dprob", {30'b0, dp_rob_available}, 0);
        tick();
        squash   = 1'b0;
        if_valid = 1'b0;
        #1;
        check_eq("sqf_count", {28'b0, ib_count}, 0);
        check_eq("sqf_valid", {31'b0, ib_dp_valid}, 0);
        check_eq("sqf_pkt",   {31'b0, |ib_dp_packet}, 0);

        // Wrap-around: 12 pushes interleaved with 12 pops
        rob_dp_available = 2'b00;
        push_n(1, 32'h300);
        rob_dp_available = 2'b10;
        for (int k = 1; k < 12; k++) begin
            if_packet = mk(32'h300 + 32'(4 * k));
            if_valid  = 1'b1;
            #1;
            check_eq("wrap_pc",    ib_dp_packet.PC, 32'h300 + 32'(4 * (k - 1)));
            check_eq("wrap_count", {28'b0, ib_count}, 1);
            tick();
        end
        if_valid = 1'b0;
        #1;
        check_eq("wrap_last_pc", ib_dp_packet.PC, 32'h32C);
        tick();
        #1;
        check_eq("wrap_empty", {31'b0, ib_dp_valid}, 0);

        // Squash at count 5 with a push pending
        rob_dp_available = 2'b00;
        push_n(5, 32'h500);
        #1;
        check_eq("sq5_count_pre", {28'b0, ib_count}, 5);
        squash    = 1'b1;
        if_packet = mk(32'h777);
        if_valid  = 1'b1;
        tick();
        squash   = 1'b0;
        if_valid = 1'b0;
        #1;
        check_eq("sq5_count", {28'b0, ib_count}, 0);
        check_eq("sq5_valid", {31'b0, ib_dp_valid}, 0);
        push_n(1, 32'h900);
        #1;
        check_eq("sq5_next_pc",    ib_dp_packet.PC, 32'h900);
        check_eq("sq5_next_count", {28'b0, ib_count}, 1);

        // RS busy blocks dispatch
        rob_dp_available = 2'b10;
        rs_available     = 1'b0;
        #1;
        check_eq("rsb_dprob", {30'b0, dp_rob_available}, 0);
        tick();
        #1;
        check_eq("rsb_count", {28'b0, ib_count}, 1);
        check_eq("rsb_pc",    ib_dp_packet.PC, 32'h900);

        // Asynchronous reset mid-stream, between clock edges
        reset = 1'b1;
        #1;
        check_eq("arst_count", {28'b0, ib_count}, 0);
        check_eq("arst_valid", {31'b0, ib_dp_valid}, 0);
        check_eq("arst_ready", {31'b0, ib_if_ready}, 1);
        check_eq("arst_pkt",   {31'b0, |ib_dp_packet}, 0);
        check_eq("arst_dprob", {30'b0, dp_rob_available}, 0);
        tick();
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
